sobel_pipe_accelerator: RTL and testbench
=========================================

Name: sobel_pipe_accelerator

Overview:
Parametrised, pipelined successor to the combinational Sobel core. Takes three image-row slices per beat over a valid/ready handshake and computes NUM_LANES Sobel output pixels per beat. Supports selectable gradient modes and back-pressure from the write path. Sits between the row-register block and the output-buffer writer.

Parameters:
NUM_LANES, 16, output pixels per beat; input slice is NUM_LANES+2 pixels per row.
PIX_WIDTH, 8, bits per pixel (in and out).
CNT_WIDTH, 32, width of the output beat counter.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_row1, in_row2, in_row3  in  (NUM_LANES+2)*PIX_WIDTH each  row slices; pixel k occupies bits [(k+1)*PIX_WIDTH-1 : k*PIX_WIDTH].
in_mode  in  2  gradient mode, travels with the beat.
in_last  in  1  marks the final beat of an image row, travels with the beat.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts when out_valid && out_ready.
out_data  out  NUM_LANES*PIX_WIDTH  lane c result in bits [(c+1)*PIX_WIDTH-1 : c*PIX_WIDTH].
out_last  out  1  in_last of the beat delivered.
out_beat_count  out  CNT_WIDTH  count of completed output handshakes.

Behaviour:
- Lane c uses window columns c, c+1, c+2 (column c+2 = "left", column c = "right"); rows 1..3 are top..bottom.
- gx = (r1[c+2] + 2*r1[c+1] + r1[c]) - (r3[c+2] + 2*r3[c+1] + r3[c]); gy = (r1[c+2] + 2*r2[c+2] + r3[c+2]) - (r1[c] + 2*r2[c] + r3[c]).
- gx and gy are signed, PIX_WIDTH+3 bits; no intermediate truncation.
- in_mode: 00 = |gx|+|gy|; 01 = |gx|; 10 = |gy|; 11 = max(|gx|,|gy|). Result is unsigned PIX_WIDTH+3 bits, saturated to 2^PIX_WIDTH-1.
- Three pipeline stages:
  - S1: registers the weighted top/bottom/left/right column sums.
  - S2: registers |gx| and |gy|.
  - S3: registers the mode-combined, saturated pixel.
- Each stage has a valid bit. mode and last are carried alongside the data.
- Latency is exactly 3 cycles from the input handshake to out_valid when out_ready stays high. Throughput is one beat per cycle.
- Stall rule: stall = S3 valid && !out_ready. When stalled, all stages hold. Otherwise all stages advance together; bubbles are not collapsed.
- in_ready = !stall, driven combinationally from out_ready. in_row*, in_mode and in_last are ignored when in_valid=0.
- out_data, out_last and out_valid come directly from the S3 registers and stay stable while out_valid && !out_ready.
- out_beat_count increments by 1 per output handshake and wraps at 2^CNT_WIDTH. in_last does not clear it.
- Reset (may assert at any time, including mid-stream): all valid bits 0, out_data 0, out_last 0, out_beat_count 0. In-flight beats are discarded. in_ready goes high once reset deasserts.
- Simultaneous input and output handshakes in the same cycle are legal and are the steady state.

Optional Feature:
SOBEL_THRESHOLD_EN
- Defined: adds input port threshold (PIX_WIDTH, quasi-static). S3 outputs 2^PIX_WIDTH-1 when the saturated result >= threshold, else 0. Latency is unchanged.
- Undefined: the threshold port is absent and S3 outputs the saturated result.

Decomposition:
- Shared package/defines header holds:
  - mode encodings: SOBEL_MODE_SUM, SOBEL_MODE_X, SOBEL_MODE_Y, SOBEL_MODE_MAX;
  - default NUM_LANES (tied to NUM_SOBEL_ACCELERATORS);
  - default PIX_WIDTH;
  - pipeline depth constant SOBEL_PIPE_LATENCY = 3.
- One sub-module, sobel_lane, holds the per-lane S1–S3 datapath and is generated NUM_LANES times. The top level owns the valid/stall control, the mode/last sideband and the counter.

Test Plan:
1. All rows uniform 0x80, mode 00, out_ready=1 -> out_data all 0x00 three cycles after the handshake; out_beat_count=1.
2. Every row has pixels [0..k] = 0 and pixels above k = 0xFF (vertical edge) -> lanes straddling the edge give gy=1020, saturated to 0xFF in mode 00. Mode 01 gives 0x00 on those lanes.
3. Row1 all 0x0A, row2 arbitrary uniform, row3 all 0x00 -> gx=40, so mode 00 = 0x28, mode 01 = 0x28, mode 10 = 0x00, mode 11 = 0x28. Check per-beat mode changes are honoured back to back.
4. Stream 6 beats, hold out_ready low for 5 cycles after the first out_valid -> in_ready low while stalled, no beat lost or duplicated, order and out_last preserved, out_beat_count=6 at the end.
5. Assert reset mid-stream with 2 beats in flight -> out_valid=0 immediately (asynchronously), out_beat_count=0, the next beat after reset emerges after exactly 3 cycles.
6. With SOBEL_THRESHOLD_EN and threshold=0x30: test 3 data in mode 00 -> 0x00; vertical-edge data -> 0xFF on edge lanes.

Source files
------------

// File: rtl/sobel_pipe_accelerator_pkg.sv
// Shared constants and types for the pipelined Sobel accelerator.
// Optional build macro used by the design: SOBEL_THRESHOLD_EN.
package sobel_pipe_accelerator_pkg;

  // Number of parallel Sobel engines in the accelerator.
  localparam int NUM_SOBEL_ACCELERATORS = 16;
  localparam int SOBEL_NUM_LANES        = NUM_SOBEL_ACCELERATORS;
  localparam int SOBEL_PIX_WIDTH        = 8;
  localparam int SOBEL_PIPE_LATENCY     = 3;

  typedef enum logic [1:0] {
    SOBEL_MODE_SUM = 2'b00,
    SOBEL_MODE_X   = 2'b01,
    SOBEL_MODE_Y   = 2'b10,
    SOBEL_MODE_MAX = 2'b11
  } sobel_mode_e;

  // Per-beat sideband that travels alongside the pixel data.
  typedef struct packed {
    sobel_mode_e mode;
    logic        last;
  } sobel_side_t;

endpackage

// File: rtl/sobel_pipe_accelerator_lane.sv
// One Sobel output lane: S1 weighted column sums, S2 |gx|/|gy|,
// S3 mode combine + saturate (+ binarise when SOBEL_THRESHOLD_EN).
// Index 0 of each 3-pixel window is the right column (c), index 2 the left (c+2).
module sobel_lane
  import sobel_pipe_accelerator_pkg::*;
#(
  parameter int PIX_WIDTH = SOBEL_PIX_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adv,
  input  logic [2:0][PIX_WIDTH-1:0] row1,
  input  logic [PIX_WIDTH-1:0]      row2_l,
  input  logic [PIX_WIDTH-1:0]      row2_r,
  input  logic [2:0][PIX_WIDTH-1:0] row3,
  input  sobel_mode_e               mode_s2,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_WIDTH-1:0]      threshold,
`endif
  output logic [PIX_WIDTH-1:0]      pix
);

  // Weighted column sum peaks at 4*(2^P-1); gradients need one sign bit on top.
  localparam int SW = PIX_WIDTH + 2;
  localparam int GW = PIX_WIDTH + 3;

  logic [SW-1:0] top_d, bot_d, lft_d, rgt_d;
  logic [SW-1:0] top_q, bot_q, lft_q, rgt_q;
  logic signed [GW-1:0] gx_d, gy_d;
  logic [SW-1:0] ax_d, ay_d, ax_q, ay_q;
  logic [GW-1:0] comb_d;
  logic [PIX_WIDTH-1:0] sat_d, res_d;

  // S1 inputs: 1-2-1 weighted sums of top/bottom rows and left/right columns
  always_comb begin
    top_d = SW'(row1[2]) + (SW'(row1[1]) << 1) + SW'(row1[0]);
    bot_d = SW'(row3[2]) + (SW'(row3[1]) << 1) + SW'(row3[0]);
    lft_d = SW'(row1[2]) + (SW'(row2_l) << 1) + SW'(row3[2]);
    rgt_d = SW'(row1[0]) + (SW'(row2_r) << 1) + SW'(row3[0]);
  end

  // S2 inputs: signed gradients and their magnitudes (magnitude fits SW bits)
  always_comb begin
    gx_d = $signed({1'b0, top_q}) - $signed({1'b0, bot_q});
    gy_d = $signed({1'b0, lft_q}) - $signed({1'b0, rgt_q});
    ax_d = gx_d[GW-1] ? SW'(-gx_d) : SW'(gx_d);
    ay_d = gy_d[GW-1] ? SW'(-gy_d) : SW'(gy_d);
  end

  // S3 inputs: combine per the mode of the beat leaving S2, then saturate
  always_comb begin
    case (mode_s2)
      SOBEL_MODE_X:   comb_d = GW'(ax_q);
      SOBEL_MODE_Y:   comb_d = GW'(ay_q);
      SOBEL_MODE_MAX: comb_d = (ax_q >= ay_q) ? GW'(ax_q) : GW'(ay_q);
      default:        comb_d = GW'(ax_q) + GW'(ay_q);
    endcase
    sat_d = (|comb_d[GW-1:PIX_WIDTH]) ? '1 : comb_d[PIX_WIDTH-1:0];
`ifdef SOBEL_THRESHOLD_EN
    res_d = (sat_d >= threshold) ? '1 : '0;
`else
    res_d = sat_d;
`endif
  end

  // Pipeline registers; all stages hold together while the output is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      bot_q <= '0;
      lft_q <= '0;
      rgt_q <= '0;
      ax_q  <= '0;
      ay_q  <= '0;
      pix   <= '0;
    end else if (adv) begin
      top_q <= top_d;
      bot_q <= bot_d;
      lft_q <= lft_d;
      rgt_q <= rgt_d;
      ax_q  <= ax_d;
      ay_q  <= ay_d;
      pix   <= res_d;
    end
  end

endmodule

// File: rtl/sobel_pipe_accelerator.sv
// Pipelined multi-lane Sobel accelerator with valid/ready on both sides.
// Owns the valid/stall control, mode/last sideband and output beat counter;
// the per-lane datapath lives in sobel_lane.
// Optional build macro: SOBEL_THRESHOLD_EN (adds the threshold input).
module sobel_pipe_accelerator
  import sobel_pipe_accelerator_pkg::*;
#(
  parameter int NUM_LANES = SOBEL_NUM_LANES,
  parameter int PIX_WIDTH = SOBEL_PIX_WIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] in_row1,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] in_row2,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] in_row3,
  input  logic [1:0]                        in_mode,
  input  logic                              in_last,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_WIDTH-1:0]              threshold,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANES*PIX_WIDTH-1:0]    out_data,
  output logic                              out_last,
  output logic [CNT_WIDTH-1:0]              out_beat_count
);

  localparam int STAGES = SOBEL_PIPE_LATENCY;

  // Stage 0 is the live input beat; stages 1..STAGES are registered.
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q;
  sobel_side_t       side_in;
  sobel_side_t [STAGES-1:0] side_pipe;
  sobel_side_t [STAGES-1:1] side_q;
  logic              last_s3;
  logic              stall, adv;
  logic [NUM_LANES-1:0][PIX_WIDTH-1:0] lane_pix;

  assign side_in   = '{mode: sobel_mode_e'(in_mode), last: in_last};
  assign vld_pipe  = {vld_q, in_valid};
  assign side_pipe = {side_q, side_in};

  assign stall    = vld_pipe[STAGES] && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  assign out_valid      = vld_q[STAGES];
  assign out_last       = last_s3;
  assign out_data       = lane_pix;

  // Valid/sideband shift register; bubbles advance like beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      side_q  <= '0;
      last_s3 <= 1'b0;
    end else if (adv) begin
      vld_q   <= vld_pipe[STAGES-1:0];
      side_q  <= side_pipe[STAGES-2:0];
      last_s3 <= side_q[STAGES-1].last;
    end
  end

  // Count completed output handshakes; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_beat_count <= '0;
    else if (vld_pipe[STAGES] && out_ready)
      out_beat_count <= out_beat_count + CNT_WIDTH'(1);
  end

  // Lane c sees input pixels c..c+2 of each row
  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    sobel_lane #(
      .PIX_WIDTH (PIX_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .row1      (in_row1[c*PIX_WIDTH +: 3*PIX_WIDTH]),
      .row2_l    (in_row2[(c+2)*PIX_WIDTH +: PIX_WIDTH]),
      .row2_r    (in_row2[c*PIX_WIDTH +: PIX_WIDTH]),
      .row3      (in_row3[c*PIX_WIDTH +: 3*PIX_WIDTH]),
      .mode_s2   (side_q[STAGES-1].mode),
`ifdef SOBEL_THRESHOLD_EN
      .threshold (threshold),
`endif
      .pix       (lane_pix[c])
    );
  end

endmodule

// File: tb/tb_sobel_pipe_accelerator.sv
// Directed self-checking bench for sobel_pipe_accelerator (16 lanes, 8-bit pixels).
// Honours SOBEL_THRESHOLD_EN by binarising expected pixels against 0x30.
module tb_sobel_pipe_accelerator;

  localparam int NL = 16;
  localparam int PW = 8;
  localparam int CW = 32;
  localparam int RW = (NL + 2) * PW;
  localparam int OW = NL * PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row1 = '0, in_row2 = '0, in_row3 = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_beat_count;
`ifdef SOBEL_THRESHOLD_EN
  logic [PW-1:0] threshold = 8'h30;
`endif

  sobel_pipe_accelerator #(.NUM_LANES(NL), .PIX_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_row1        (in_row1),
    .in_row2        (in_row2),
    .in_row3        (in_row3),
    .in_mode        (in_mode),
    .in_last        (in_last),
`ifdef SOBEL_THRESHOLD_EN
    .threshold      (threshold),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_beat_count (out_beat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Burst tables
  logic [RW-1:0] b_r1 [16];
  logic [RW-1:0] b_r2 [16];
  logic [RW-1:0] b_r3 [16];
  logic [1:0]    b_mode [16];
  logic          b_last [16];
  logic [OW-1:0] e_data [16];
  int            nb;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] urow(input logic [7:0] v);
    logic [RW-1:0] r;
    for (int p = 0; p < NL + 2; p++) r[p*PW +: PW] = v;
    return r;
  endfunction

  // Pixels 0..k are 0, pixels above k are hi
  function automatic logic [RW-1:0] step_row(input int k, input logic [7:0] hi);
    logic [RW-1:0] r;
    for (int p = 0; p < NL + 2; p++) r[p*PW +: PW] = (p > k) ? hi : 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] thr(input logic [7:0] v);
`ifdef SOBEL_THRESHOLD_EN
    return (v >= 8'h30) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  function automatic logic [OW-1:0] uexp(input logic [7:0] v);
    logic [OW-1:0] r;
    for (int c = 0; c < NL; c++) r[c*PW +: PW] = thr(v);
    return r;
  endfunction

  // Lanes 0..5 zero, lane 6 = v6, lane 7 = v7, lanes 8.. = v8
  function automatic logic [OW-1:0] edge_exp(input logic [7:0] v6, input logic [7:0] v7,
                                             input logic [7:0] v8);
    logic [OW-1:0] r;
    for (int c = 0; c < NL; c++)
      r[c*PW +: PW] = (c < 6) ? thr(8'h00) : (c == 6) ? thr(v6) : (c == 7) ? thr(v7) : thr(v8);
    return r;
  endfunction

  // Stream nb beats back to back with out_ready high; beat i must appear 3 cycles later
  task automatic run_burst(input string tag);
    for (int i = 0; i < nb + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk($sformatf("%s[%0d]_vld", tag, i - 3), OW'(out_valid), OW'(1'b1));
        chk($sformatf("%s[%0d]_data", tag, i - 3), out_data, e_data[i-3]);
        chk($sformatf("%s[%0d]_last", tag, i - 3), OW'(out_last), OW'(b_last[i-3]));
      end else begin
        chk($sformatf("%s_lat%0d_vld", tag, i), OW'(out_valid), OW'(1'b0));
      end
      if (i < nb) begin
        in_valid = 1'b1;
        in_row1  = b_r1[i];
        in_row2  = b_r2[i];
        in_row3  = b_r3[i];
        in_mode  = b_mode[i];
        in_last  = b_last[i];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int sent, got, first;
    logic [OW-1:0] held;

    // Reset state
    #1;
    chk("rst_vld", OW'(out_valid), OW'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_last", OW'(out_last), OW'(1'b0));
    chk("rst_cnt", OW'(out_beat_count), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", OW'(in_ready), OW'(1'b1));

    // 1: flat image gives zero gradient
    nb = 1;
    b_r1[0] = urow(8'h80); b_r2[0] = urow(8'h80); b_r3[0] = urow(8'h80);
    b_mode[0] = 2'b00; b_last[0] = 1'b1; e_data[0] = uexp(8'h00);
    run_burst("t1_flat");
    @(negedge clk);
    chk("t1_cnt", OW'(out_beat_count), OW'(32'd1));

    // 2: vertical edge between pixels 7 and 8; gy = 1020 on lanes 6,7
    nb = 4;
    for (int i = 0; i < 4; i++) begin
      b_r1[i] = step_row(7, 8'hFF); b_r2[i] = step_row(7, 8'hFF); b_r3[i] = step_row(7, 8'hFF);
      b_mode[i] = 2'(i); b_last[i] = (i == 3);
    end
    e_data[0] = edge_exp(8'hFF, 8'hFF, 8'h00);
    e_data[1] = uexp(8'h00);
    e_data[2] = edge_exp(8'hFF, 8'hFF, 8'h00);
    e_data[3] = edge_exp(8'hFF, 8'hFF, 8'h00);
    run_burst("t2_edge");

    // 3: horizontal gradient gx = +/-40, per-beat mode changes
    nb = 5;
    for (int i = 0; i < 4; i++) begin
      b_r1[i] = urow(8'h0A); b_r2[i] = urow(8'h55); b_r3[i] = urow(8'h00);
      b_mode[i] = 2'(i); b_last[i] = i[0];
    end
    b_r1[4] = urow(8'h00); b_r2[4] = urow(8'h21); b_r3[4] = urow(8'h0A);
    b_mode[4] = 2'b01; b_last[4] = 1'b1;
    e_data[0] = uexp(8'h28); e_data[1] = uexp(8'h28); e_data[2] = uexp(8'h00);
    e_data[3] = uexp(8'h28); e_data[4] = uexp(8'h28);
    run_burst("t3_modes");

    // 3b: both gradients nonzero, saturation in each mode
    // lane6: gx=64 gy=192; lane7: gx=192 gy=192; lane8+: gx=256 gy=0
    nb = 4;
    for (int i = 0; i < 4; i++) begin
      b_r1[i] = step_row(7, 8'h40); b_r2[i] = step_row(7, 8'h40); b_r3[i] = urow(8'h00);
      b_mode[i] = 2'(i); b_last[i] = 1'b0;
    end
    e_data[0] = edge_exp(8'hFF, 8'hFF, 8'hFF);
    e_data[1] = edge_exp(8'h40, 8'hC0, 8'hFF);
    e_data[2] = edge_exp(8'hC0, 8'hC0, 8'h00);
    e_data[3] = edge_exp(8'hC0, 8'hC0, 8'hFF);
    run_burst("t3_sat");

    // 4: six beats with a 5-cycle output stall
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      b_r1[j] = urow(8'(4 * (j + 1))); b_r2[j] = urow(8'h33); b_r3[j] = urow(8'h00);
      b_mode[j] = 2'b01; b_last[j] = (j == 2) || (j == 5);
      e_data[j] = uexp(8'(16 * (j + 1)));
    end
    sent = 0; got = 0; first = -1; held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (first < 0 && out_valid) begin
        first = cyc;
        held  = out_data;
      end
      out_ready = !(first >= 0 && cyc < first + 5);
      if (sent < 6) begin
        in_valid = 1'b1;
        in_row1 = b_r1[sent]; in_row2 = b_r2[sent]; in_row3 = b_r3[sent];
        in_mode = b_mode[sent]; in_last = b_last[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (first >= 0 && cyc < first + 5) begin
        chk($sformatf("t4_stall%0d_rdy", cyc - first), OW'(in_ready), OW'(1'b0));
        chk($sformatf("t4_stall%0d_vld", cyc - first), OW'(out_valid), OW'(1'b1));
        chk($sformatf("t4_stall%0d_hold", cyc - first), out_data, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("t4[%0d]_data", got), out_data, e_data[got]);
        chk($sformatf("t4[%0d]_last", got), OW'(out_last), OW'(b_last[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t4_got", OW'(got), OW'(6));
    chk("t4_sent", OW'(sent), OW'(6));
    @(negedge clk);
    chk("t4_cnt", OW'(out_beat_count), OW'(32'd6));
    chk("t4_drained", OW'(out_valid), OW'(1'b0));

    // 5: reset with two beats in flight
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_row1 = urow(8'h14); in_row2 = urow(8'h00); in_row3 = urow(8'h00);
    in_mode = 2'b01; in_last = 1'b1;
    @(negedge clk);
    in_row1 = urow(8'h18);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_pre_vld", OW'(out_valid), OW'(1'b1));
    chk("t5_pre_data", out_data, uexp(8'h50));
    chk("t5_pre_cnt", OW'(out_beat_count), OW'(32'd6));
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_vld", OW'(out_valid), OW'(1'b0));
    chk("t5_rst_data", out_data, '0);
    chk("t5_rst_last", OW'(out_last), OW'(1'b0));
    chk("t5_rst_cnt", OW'(out_beat_count), '0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t5_post_rdy", OW'(in_ready), OW'(1'b1));
    nb = 1;
    b_r1[0] = urow(8'h08); b_r2[0] = urow(8'h77); b_r3[0] = urow(8'h00);
    b_mode[0] = 2'b01; b_last[0] = 1'b0; e_data[0] = uexp(8'h20);
    run_burst("t5_post");
    @(negedge clk);
    chk("t5_post_cnt", OW'(out_beat_count), OW'(32'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
